mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and write-back formatter of the 5-stage pipelined MIPS core. Captures memory-stage results on the rising clock edge and selects the write-back source: ALU result, load data or link address. Load data is byte/half extracted and sign- or zero-extended. The stage drives the register-file write port (RegWrite/RDaddr/RDdata), which commits on the following falling edge. It also exports a forwarding tap and a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold all stage state
- flush_i  in  1  capture a bubble
- valid_i  in  1  upstream slot holds a real instruction
- RegWrite_i  in  1  instruction writes a register
- RDaddr_i  in  ADDR_W  destination register
- WBsel_i  in  2  0=ALU, 1=MEM, 2=LINK, 3=reserved (treated as ALU)
- MemOp_i  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, others treated as LW
- ALUres_i  in  DATA_W  ALU result / load address
- MEMdata_i  in  DATA_W  aligned word read from data memory
- PCplus4_i  in  DATA_W  link value for JAL/JALR
- valid_o  out  1  stage holds a real instruction
- RegWrite_o  out  1  register-file write enable
- RDaddr_o  out  ADDR_W  register-file write address
- RDdata_o  out  DATA_W  register-file write data
- fwd_en_o  out  1  RegWrite_o && RDaddr_o != 0, for the forwarding unit
- retire_cnt_o  out  32  retired-instruction count

## Operation
- Update priority on each posedge: rst_i > flush_i > stall_i > capture.
- Capture:
  - valid_o <= valid_i.
  - RegWrite_o <= valid_i & RegWrite_i & (RDaddr_i != 0).
  - RDaddr_o <= RDaddr_i.
  - RDdata_o <= formatted write-back value.
- Flush: valid_o, RegWrite_o, RDaddr_o and RDdata_o all go to 0. Flush wins over a simultaneous stall.
- Stall: all registers hold. RegWrite_o stays asserted if already set, so the register file rewrites the same value each falling edge. This repeat write is required to be idempotent.
- Write-back formatting:
  - Fully combinational ahead of the register.
  - Lane select uses ALUres_i[1:0], little-endian.
  - LB/LBU: byte = MEMdata_i[8*a+7 : 8*a] with a = ALUres_i[1:0]. LB sign-extends, LBU zero-extends.
  - LH/LHU: half = MEMdata_i[16*h+15 : 16*h] with h = ALUres_i[1]. ALUres_i[0] is ignored, so misaligned accesses are never trapped here. LH sign-extends, LHU zero-extends.
  - LW: MEMdata_i passes unmodified.
  - When WBsel_i != MEM, MemOp_i is ignored.
- retire_cnt_o:
  - Increments by 1 on each capture with valid_i=1.
  - Does not increment on stall, flush or bubble.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: 1 cycle from inputs to outputs. All outputs are registered; none is combinational from the inputs.
- Register file commits at the negedge in the middle of the cycle the outputs are valid. An ID-stage read of the same register in the second half of that cycle sees the new value.
- Reset: every output is 0 immediately on rst_i assertion (asynchronous), including retire_cnt_o. Reset asserted mid-stall or mid-flush also clears everything; the first capture happens on the first posedge after deassertion.
- fwd_en_o is valid in the same cycle as RegWrite_o.

## Structure
- Shared package cpu_pkg holds:
  - enum wb_sel_e (WB_ALU, WB_MEM, WB_LINK)
  - enum mem_op_e (MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU)
  - DATA_W and ADDR_W defaults
- One combinational sub-module, load_extend (inputs MemOp, addr[1:0], word; output formatted word), instantiated once. It is reused later by the store/load unit.

## Test plan
- Reset: assert rst_i between edges -> all outputs 0 immediately, retire_cnt_o=0.
- Load formatting: WBsel=MEM, MEMdata=0x80F17F02.
  - LB, addr 0x..3 -> 0xFFFFFF80.
  - LBU, addr 0x..3 -> 0x00000080.
  - LH, addr 0x..2 -> 0xFFFF80F1.
  - LHU, addr 0x..1 -> 0x00007F02.
  - LW -> 0x80F17F02.
- Link: WBsel=LINK, PCplus4=0x00400010, RDaddr=31 -> RDdata_o=0x00400010, RegWrite_o=1 one cycle later.
- $zero: RegWrite_i=1, RDaddr_i=0 -> RegWrite_o=0, fwd_en_o=0, retire_cnt_o still increments.
- Stall then flush: capture ALU 0x1234 to r5, then stall 3 cycles -> outputs held and counter +1 total. Assert stall_i and flush_i together -> valid_o=0, RegWrite_o=0, RDdata_o=0.
- Counter wrap: force 0xFFFFFFFF via 2^32-1 preload path in bench (or long run), capture one valid instruction -> retire_cnt_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 5-stage MIPS pipeline.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        MEM_LW  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LHU = 3'd2,
        MEM_LB  = 3'd3,
        MEM_LBU = 3'd4
    } mem_op_e;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Byte/half lane extraction with sign or zero extension for loads.
import cpu_pkg::*;

module load_extend #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [2:0]        mem_op_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{addr_i, 3'b000} +: 8];
        // Halfword lane ignores addr bit 0; misalignment is not trapped here.
        half_v = word_i[{addr_i[1], 4'b0000} +: 16];
        data_o = word_i;
        case (mem_op_i)
            MEM_LB:  data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            MEM_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_v};
            MEM_LH:  data_o = {{(DATA_W-16){half_v[15]}}, half_v};
            MEM_LHU: data_o = {{(DATA_W-16){1'b0}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back source select, load formatting,
// register-file write port, forwarding tap and retired-instruction counter.
import cpu_pkg::*;

module mem_wb_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [1:0]        WBsel_i,
    input  logic [2:0]        MemOp_i,
    input  logic [DATA_W-1:0] ALUres_i,
    input  logic [DATA_W-1:0] MEMdata_i,
    input  logic [DATA_W-1:0] PCplus4_i,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic              fwd_en_o,
    output logic [31:0]       retire_cnt_o
);

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wb_data;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .mem_op_i (MemOp_i),
        .addr_i   (ALUres_i[1:0]),
        .word_i   (MEMdata_i),
        .data_o   (ld_data)
    );

    always_comb begin
        wb_data = ALUres_i;
        case (WBsel_i)
            WB_MEM:  wb_data = ld_data;
            WB_LINK: wb_data = PCplus4_i;
            default: wb_data = ALUres_i;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
            data_d  = '0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            we_d    = valid_i & RegWrite_i & (RDaddr_i != '0);
            rd_d    = RDaddr_i;
            data_d  = wb_data;
            cnt_d   = cnt_q + {31'd0, valid_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign RegWrite_o   = we_q;
    assign RDaddr_o     = rd_q;
    assign RDdata_o     = data_q;
    assign fwd_en_o     = we_q && (rd_q != '0);
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic        RegWrite_i;
    logic [4:0]  RDaddr_i;
    logic [1:0]  WBsel_i;
    logic [2:0]  MemOp_i;
    logic [31:0] ALUres_i;
    logic [31:0] MEMdata_i;
    logic [31:0] PCplus4_i;
    logic        valid_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        fwd_en_o;
    logic [31:0] retire_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .RegWrite_i   (RegWrite_i),
        .RDaddr_i     (RDaddr_i),
        .WBsel_i      (WBsel_i),
        .MemOp_i      (MemOp_i),
        .ALUres_i     (ALUres_i),
        .MEMdata_i    (MEMdata_i),
        .PCplus4_i    (PCplus4_i),
        .valid_o      (valid_o),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .fwd_en_o     (fwd_en_o),
        .retire_cnt_o (retire_cnt_o)
    );

    typedef struct {
        string       name;
        logic [1:0]  wbsel;
        logic [2:0]  memop;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic v, input logic we,
                           input logic [4:0] rd, input logic [31:0] d);
        chk({nm, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({nm, ".we"}, {31'd0, RegWrite_o}, {31'd0, we});
        chk({nm, ".fwd"}, {31'd0, fwd_en_o}, {31'd0, we && rd != 0});
        chk({nm, ".rd"}, {27'd0, RDaddr_o}, {27'd0, rd});
        chk({nm, ".data"}, RDdata_o, d);
        chk({nm, ".cnt"}, retire_cnt_o, exp_cnt);
    endtask

    function automatic vec_t mk(string n, logic [1:0] ws, logic [2:0] mo,
                                logic [31:0] a, logic [31:0] m,
                                logic [31:0] p, logic [4:0] rd, logic rw,
                                logic [31:0] ed, logic ew);
        vec_t v;
        v.name = n; v.wbsel = ws; v.memop = mo; v.alu = a; v.mem = m;
        v.pc = p; v.rd = rd; v.regw = rw; v.exp_data = ed; v.exp_we = ew;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        valid_i    = vld;
        RegWrite_i = v.regw;
        RDaddr_i   = v.rd;
        WBsel_i    = v.wbsel;
        MemOp_i    = v.memop;
        ALUres_i   = v.alu;
        MEMdata_i  = v.mem;
        PCplus4_i  = v.pc;
    endtask

    initial begin
        localparam logic [31:0] M = 32'h80F17F02;
        vec_t g;
        vecs.push_back(mk("lb3",  1, 3, 32'h1003, M, 0, 2, 1, 32'hFFFFFF80, 1));
        vecs.push_back(mk("lbu3", 1, 4, 32'h1003, M, 0, 3, 1, 32'h00000080, 1));
        vecs.push_back(mk("lh2",  1, 1, 32'h1002, M, 0, 4, 1, 32'hFFFF80F1, 1));
        vecs.push_back(mk("lhu1", 1, 2, 32'h1001, M, 0, 6, 1, 32'h00007F02, 1));
        vecs.push_back(mk("lw",   1, 0, 32'h1000, M, 0, 7, 1, 32'h80F17F02, 1));
        vecs.push_back(mk("lb1",  1, 3, 32'h1001, M, 0, 8, 1, 32'h0000007F, 1));
        vecs.push_back(mk("lh3",  1, 1, 32'h1003, M, 0, 9, 1, 32'hFFFF80F1, 1));
        vecs.push_back(mk("lbu0", 1, 4, 32'h1000, M, 0, 10, 1, 32'h00000002, 1));
        vecs.push_back(mk("op7",  1, 7, 32'h1001, M, 0, 11, 1, 32'h80F17F02, 1));
        vecs.push_back(mk("alu",  0, 3, 32'hDEADBEEF, M, 0, 12, 1,
                          32'hDEADBEEF, 1));
        vecs.push_back(mk("rsvd", 3, 3, 32'h0000CAFE, M, 1, 13, 1,
                          32'h0000CAFE, 1));
        vecs.push_back(mk("link", 2, 3, 32'h5, M, 32'h00400010, 31, 1,
                          32'h00400010, 1));
        vecs.push_back(mk("zero", 0, 0, 32'h77, M, 0, 0, 1, 32'h77, 0));
        vecs.push_back(mk("nowr", 0, 0, 32'h99, M, 0, 14, 0, 32'h99, 0));

        rst_i = 1'b1; stall_i = 0; flush_i = 0;
        drive(vecs[0], 1'b0);
        #2;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i], 1'b1);
            @(posedge clk_i);
            exp_cnt++;
            #1;
            chk_all(vecs[i].name, 1, vecs[i].exp_we, vecs[i].rd,
                    vecs[i].exp_data);
        end

        // Capture r5 <= 0x1234, then hold for three stalled cycles.
        g = mk("st", 0, 0, 32'h1234, 0, 0, 5, 1, 32'h1234, 1);
        @(negedge clk_i);
        drive(g, 1'b1);
        @(posedge clk_i);
        exp_cnt++;
        #1;
        chk_all("st_cap", 1, 1, 5, 32'h1234);
        @(negedge clk_i);
        stall_i = 1'b1;
        drive(mk("x", 2, 0, 32'hAAAA, 0, 32'hBBBB, 9, 1, 0, 0), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            chk_all("st_hold", 1, 1, 5, 32'h1234);
        end
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_all("st_flush", 0, 0, 0, 0);
        @(negedge clk_i);
        stall_i = 1'b0; flush_i = 1'b0;
        drive(g, 1'b0);
        @(posedge clk_i);
        #1;
        chk_all("bubble", 0, 0, 5, 32'h1234);

        // Counter wrap via preload.
        @(negedge clk_i);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 32'hFFFFFFFF;
        chk("preload", retire_cnt_o, exp_cnt);
        drive(g, 1'b1);
        @(posedge clk_i);
        exp_cnt = 0;
        #1;
        chk_all("wrap", 1, 1, 5, 32'h1234);

        // Asynchronous reset mid-stall.
        @(negedge clk_i);
        stall_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        exp_cnt = 0;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0; stall_i = 1'b0;
        drive(vecs[11], 1'b1);
        @(posedge clk_i);
        exp_cnt = 1;
        #1;
        chk_all("post_rst", 1, 1, 31, 32'h00400010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
